prog_rom_arbiter: RTL and testbench

//  Shares the single read port of the 1024x18 synchronous program ROM between two requesters:

---
 rtl/prog_rom_arbiter.sv | 55 +++++
 tb/tb_prog_rom_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_rom_arbiter.sv
// prog_rom_arbiter: shares the program ROM read port between fetch (A) and debug (B), tagging returned data.
// Optional STARVE_GUARD_EN bounds B's wait to MAX_WAIT+1 cycles under continuous fetch.
module prog_rom_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 18,
  parameter int MAX_WAIT = 8
) (
  input  logic              PROG_CLK,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_valid,
  output logic [DATA_W-1:0] a_data,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_gnt,
  output logic              b_valid,
  output logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_ir
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] last_addr;
  logic force_b;
`ifdef STARVE_GUARD_EN
  logic [7:0] wait_cnt;
  assign force_b = b_req && wait_cnt == 8'(MAX_WAIT);
  always_ff @(posedge PROG_CLK or negedge rst_n)
    if (!rst_n) wait_cnt <= '0;
    else wait_cnt <= (b_gnt || !b_req) ? '0 : a_req ? wait_cnt + 8'd1 : wait_cnt;
`else
  assign force_b = 1'b0;
`endif
  // Grants are gated by rst_n directly so they drop the instant reset asserts.
  always_comb begin
    a_gnt     = rst_n && a_req && !force_b;
    b_gnt     = rst_n && b_req && (!a_req || force_b);
    rom_addr  = a_gnt ? a_addr : b_gnt ? b_addr : last_addr;
    state_nxt = a_gnt ? OWN_A : b_gnt ? OWN_B : IDLE;
  end
  always_ff @(posedge PROG_CLK or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      last_addr <= '0;
    end else begin
      state     <= state_nxt;
      last_addr <= rom_addr;
    end
  assign a_valid = state == OWN_A;
  assign b_valid = state == OWN_B;
  assign a_data  = rom_ir;
  assign b_data  = rom_ir;
endmodule

// File: tb/tb_prog_rom_arbiter.sv
// tb_prog_rom_arbiter: scoreboard bench for prog_rom_arbiter with a registered ROM model.
module tb_prog_rom_arbiter;
  localparam int AW = 10, DW = 18, MW = 8;
  logic PROG_CLK = 0, rst_n = 0;
  logic a_req = 0, b_req = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0, rom_addr;
  logic a_gnt, b_gnt, a_valid, b_valid;
  logic [DW-1:0] a_data, b_data, rom_ir;
  int total = 0, passed = 0;

  typedef struct {logic [1:0] port; logic [DW-1:0] data;} exp_t;
  exp_t q[$];
  logic [AW-1:0] m_last = '0;
  logic [7:0] m_wait = '0;

  prog_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .PROG_CLK(PROG_CLK), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_valid(a_valid), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_valid(b_valid), .b_data(b_data),
    .rom_addr(rom_addr), .rom_ir(rom_ir));

  always #5 PROG_CLK = ~PROG_CLK;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return {a[7:0], a} ^ 18'h15A3C;
  endfunction

  always @(posedge PROG_CLK) rom_ir <= rom_fn(rom_addr);

  // Reference model of the arbitration decision, from the bench's own inputs.
  function automatic logic m_force();
`ifdef STARVE_GUARD_EN
    return b_req && m_wait == 8'(MW);
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic m_agnt(); return a_req && !m_force(); endfunction
  function automatic logic m_bgnt(); return b_req && (!a_req || m_force()); endfunction

  always @(posedge PROG_CLK or negedge rst_n)
    if (!rst_n) begin
      m_last <= '0;
      m_wait <= '0;
    end else begin
      m_last <= m_agnt() ? a_addr : m_bgnt() ? b_addr : m_last;
      m_wait <= (m_bgnt() || !b_req) ? 8'd0 : a_req ? m_wait + 8'd1 : m_wait;
    end

  // Scoreboard: each active cycle pushes the expected owner of the read; the next cycle pops and checks VALID/DATA.
  always @(negedge PROG_CLK) begin
    exp_t e;
    logic [AW-1:0] ea;
    if (!rst_n) begin
      q.delete();
      total++;
      if ({a_gnt, b_gnt, a_valid, b_valid, rom_addr} !== {4'b0, {AW{1'b0}}})
        $display("FAIL rst_outputs gnt=%b%b valid=%b%b rom_addr=%h required all 0", a_gnt, b_gnt, a_valid, b_valid, rom_addr);
      else passed++;
    end else begin
      e = q.size() > 0 ? q.pop_front() : '{2'd0, '0};
      total++;
      if ({a_valid, b_valid} !== {e.port == 2'd1, e.port == 2'd2})
        $display("FAIL sb_valid t=%0t a_valid=%b b_valid=%b required %b %b", $time, a_valid, b_valid, e.port == 2'd1, e.port == 2'd2);
      else passed++;
      if (e.port != 2'd0) begin
        total++;
        if ((e.port == 2'd1 ? a_data : b_data) !== e.data)
          $display("FAIL sb_data t=%0t port=%0d got=%h required %h", $time, e.port, e.port == 2'd1 ? a_data : b_data, e.data);
        else passed++;
      end
      ea = m_agnt() ? a_addr : m_bgnt() ? b_addr : m_last;
      total++;
      if ({a_gnt, b_gnt, rom_addr} !== {m_agnt(), m_bgnt(), ea})
        $display("FAIL sb_gnt t=%0t gnt=%b%b rom_addr=%h required %b%b %h", $time, a_gnt, b_gnt, rom_addr, m_agnt(), m_bgnt(), ea);
      else passed++;
      q.push_back(m_agnt() ? exp_t'{2'd1, rom_fn(a_addr)} : m_bgnt() ? exp_t'{2'd2, rom_fn(b_addr)} : exp_t'{2'd0, '0});
    end
  end

  task automatic next_cycle(); @(posedge PROG_CLK); #1; endtask

  task automatic test_reset();
    rst_n = 0; a_req = 1; a_addr = 10'h2AA;
    repeat (3) next_cycle();
    @(negedge PROG_CLK);
    total++;
    if ({a_gnt, rom_addr, a_valid, b_valid} !== {1'b0, {AW{1'b0}}, 2'b00})
      $display("FAIL reset_hold a_gnt=%b rom_addr=%h valid=%b%b required 0 000 00", a_gnt, rom_addr, a_valid, b_valid);
    else passed++;
    next_cycle(); rst_n = 1; #1;
    total++;
    if (a_gnt !== 1'b1) $display("FAIL reset_release a_gnt=%b required 1", a_gnt);
    else passed++;
    next_cycle(); a_req = 0;
    repeat (2) next_cycle();
  endtask

  task automatic test_a_only();
    logic [AW-1:0] seq [3] = '{10'h005, 10'h006, 10'h3FF};
    for (int i = 0; i < 3; i++) begin
      a_req = 1; a_addr = seq[i];
      @(negedge PROG_CLK);
      total++;
      if ({a_gnt, b_gnt, rom_addr} !== {2'b10, seq[i]})
        $display("FAIL a_only_gnt i=%0d gnt=%b%b rom_addr=%h required 10 %h", i, a_gnt, b_gnt, rom_addr, seq[i]);
      else passed++;
      next_cycle();
    end
    a_req = 0;
    @(negedge PROG_CLK);
    total++;
    if ({a_valid, a_data} !== {1'b1, rom_fn(10'h3FF)})
      $display("FAIL a_only_last valid=%b data=%h required 1 %h", a_valid, a_data, rom_fn(10'h3FF));
    else passed++;
    total++;
    if (rom_addr !== 10'h3FF) $display("FAIL a_only_hold rom_addr=%h required 3ff", rom_addr);
    else passed++;
    repeat (2) next_cycle();
  endtask

  task automatic test_contention();
    a_req = 1; a_addr = 10'h010; b_req = 1; b_addr = 10'h020;
    @(negedge PROG_CLK);
    total++;
    if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL contend_first gnt=%b%b required 10", a_gnt, b_gnt);
    else passed++;
    next_cycle(); a_req = 0;
    @(negedge PROG_CLK);
    total++;
    if ({b_gnt, a_valid, a_data} !== {2'b11, rom_fn(10'h010)})
      $display("FAIL contend_b_gnt b_gnt=%b a_valid=%b a_data=%h required 1 1 %h", b_gnt, a_valid, a_data, rom_fn(10'h010));
    else passed++;
    next_cycle(); b_req = 0;
    @(negedge PROG_CLK);
    total++;
    if ({b_valid, b_data, a_valid} !== {1'b1, rom_fn(10'h020), 1'b0})
      $display("FAIL contend_b_data b_valid=%b b_data=%h a_valid=%b required 1 %h 0", b_valid, b_data, a_valid, rom_fn(10'h020));
    else passed++;
    repeat (2) next_cycle();
  endtask

  task automatic test_reset_mid();
    b_req = 1; b_addr = 10'h155;
    next_cycle(); b_req = 0; rst_n = 0;
    next_cycle(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PROG_CLK);
      total++;
      if ({a_valid, b_valid} !== 2'b00) $display("FAIL reset_mid i=%0d valid=%b%b required 00", i, a_valid, b_valid);
      else passed++;
      next_cycle();
    end
  endtask

  task automatic test_starve();
    int first = 0;
    a_req = 1; b_req = 1; a_addr = 10'h0AA; b_addr = 10'h0BB;
`ifdef STARVE_GUARD_EN
    for (int k = 1; k <= 20 && first == 0; k++) begin
      @(negedge PROG_CLK);
      if (b_gnt) begin
        first = k;
        total++;
        if (a_gnt !== 1'b0) $display("FAIL starve_a_stall a_gnt=%b required 0", a_gnt);
        else passed++;
      end
      next_cycle();
    end
    b_req = 0;
    total++;
    if (first != MW + 1) $display("FAIL starve_cycle got=%0d required %0d", first, MW + 1);
    else passed++;
    @(negedge PROG_CLK);
    total++;
    if ({a_gnt, b_valid, b_data} !== {2'b11, rom_fn(10'h0BB)})
      $display("FAIL starve_after a_gnt=%b b_valid=%b b_data=%h required 1 1 %h", a_gnt, b_valid, b_data, rom_fn(10'h0BB));
    else passed++;
`else
    for (int k = 0; k < 100; k++) begin
      @(negedge PROG_CLK);
      if (b_gnt) first++;
      next_cycle();
    end
    b_req = 0;
    total++;
    if (first != 0) $display("FAIL starve_none b_gnt_count=%0d required 0", first);
    else passed++;
`endif
    a_req = 0;
    repeat (2) next_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      a_req = ($urandom_range(0, 3) != 0); a_addr = AW'($urandom);
      b_req = ($urandom_range(0, 1) != 0); b_addr = AW'($urandom);
      if (i % 997 == 996) rst_n = 0;
      else rst_n = 1;
      next_cycle();
    end
    a_req = 0; b_req = 0; rst_n = 1;
    repeat (3) next_cycle();
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_contention();
    test_reset_mid();
    test_starve();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
